// File: rtl/sdram_arbiter.sv
// Two-port Avalon arbiter in front of the SDRAM controller; returns are routed via a requester tag FIFO.
// Optional `ARB_STARVATION_GUARD_EN` forces port 1 one grant after STARVE_LIMIT port-0 accepts.
module sdram_arbiter #(
    parameter int OUTSTANDING_LOG2 = 4,
    parameter int STARVE_LIMIT     = 64
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [28:0] p0_address,
    input  logic        p0_read,
    output logic        p0_waitrequest,
    output logic [63:0] p0_readdata,
    output logic        p0_readdatavalid,
    input  logic [28:0] p1_address,
    input  logic        p1_read,
    input  logic        p1_write,
    input  logic [63:0] p1_writedata,
    input  logic [7:0]  p1_byteenable,
    output logic        p1_waitrequest,
    output logic [63:0] p1_readdata,
    output logic        p1_readdatavalid,
    output logic [28:0] m_address,
    output logic [7:0]  m_burstcount,
    output logic        m_read,
    output logic        m_write,
    output logic [63:0] m_writedata,
    output logic [7:0]  m_byteenable,
    input  logic        m_waitrequest,
    input  logic [63:0] m_readdata,
    input  logic        m_readdatavalid,
    output logic [31:0] debug_value
);
    localparam int DEPTH = 1 << OUTSTANDING_LOG2;

    typedef struct packed {
        logic [28:0] address;
        logic        read;
        logic        write;
        logic [63:0] writedata;
        logic [7:0]  byteenable;
    } cmd_t;

    typedef enum logic [1:0] {ARB_FREE, ARB_LOCK0, ARB_LOCK1} arb_state_t;

    arb_state_t                state, state_nxt;
    cmd_t [1:0]                port_cmd;
    cmd_t                      m_cmd;
    logic [1:0]                eligible;
    logic                      owner, owner_valid, prefer_p1;
    logic                      cmd_valid, accept, push, pop, stray;
    logic [DEPTH-1:0]          tag_mem;
    logic [OUTSTANDING_LOG2-1:0] wr_ptr, rd_ptr;
    logic [OUTSTANDING_LOG2:0] tag_count;
    logic                      tag_full, tag_empty, ret_tag, error_sticky;

    assign port_cmd[0] = '{address: p0_address, read: p0_read, write: 1'b0,
                           writedata: 64'd0, byteenable: 8'hFF};
    assign port_cmd[1] = '{address: p1_address, read: p1_read, write: p1_write,
                           writedata: p1_writedata, byteenable: p1_byteenable};

    // Count never exceeds DEPTH, so its MSB alone means full.
    assign tag_full  = tag_count[OUTSTANDING_LOG2];
    assign tag_empty = (tag_count == '0);

    assign eligible[0] = p0_read && !tag_full;
    assign eligible[1] = p1_write || (p1_read && !tag_full);

`ifdef ARB_STARVATION_GUARD_EN
    localparam logic [6:0] STARVE_MAX = 7'(STARVE_LIMIT);
    logic [6:0] starve_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            starve_cnt <= '0;
        else if (accept && owner)
            starve_cnt <= '0;
        else if (accept && !owner && eligible[1] && starve_cnt < STARVE_MAX)
            starve_cnt <= starve_cnt + 7'd1;
    end

    assign prefer_p1 = (starve_cnt >= STARVE_MAX);
`else
    assign prefer_p1 = 1'b0;
`endif

    // Lock FSM: holds the owner while its command waits on the controller.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= ARB_FREE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = ARB_FREE;
        if (cmd_valid && m_waitrequest)
            state_nxt = owner ? ARB_LOCK1 : ARB_LOCK0;
    end

    always_comb begin
        owner_valid = 1'b0;
        owner       = 1'b0;
        case (state)
            ARB_LOCK0: owner_valid = 1'b1;
            ARB_LOCK1: begin owner_valid = 1'b1; owner = 1'b1; end
            default: begin
                if (prefer_p1 && eligible[1]) begin
                    owner_valid = 1'b1; owner = 1'b1;
                end else if (eligible[0]) begin
                    owner_valid = 1'b1;
                end else if (eligible[1]) begin
                    owner_valid = 1'b1; owner = 1'b1;
                end
            end
        endcase
    end

    assign m_cmd        = port_cmd[owner];
    assign m_address    = m_cmd.address;
    assign m_writedata  = m_cmd.writedata;
    assign m_byteenable = m_cmd.byteenable;
    assign m_burstcount = 8'h01;
    assign m_read       = owner_valid && m_cmd.read;
    assign m_write      = owner_valid && m_cmd.write;

    assign cmd_valid = m_read || m_write;
    assign accept    = cmd_valid && !m_waitrequest;

    assign p0_waitrequest = !(owner_valid && !owner) || m_waitrequest;
    assign p1_waitrequest = !(owner_valid &&  owner) || m_waitrequest;

    assign push  = accept && m_read;
    assign pop   = m_readdatavalid && !tag_empty;
    assign stray = m_readdatavalid && tag_empty;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tag_mem      <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            tag_count    <= '0;
            error_sticky <= 1'b0;
        end else begin
            if (push) begin
                tag_mem[wr_ptr] <= owner;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   tag_count <= tag_count + 1'b1;
                2'b01:   tag_count <= tag_count - 1'b1;
                default: tag_count <= tag_count;
            endcase
            if (stray)
                error_sticky <= 1'b1;
        end
    end

    assign ret_tag          = tag_mem[rd_ptr];
    assign p0_readdatavalid = pop && !ret_tag;
    assign p1_readdatavalid = pop &&  ret_tag;
    assign p0_readdata      = m_readdata;
    assign p1_readdata      = m_readdata;

    assign debug_value = {error_sticky, 10'b0, 5'(tag_count), 8'b0,
                          (state != ARB_FREE), 6'b0, owner};
endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: directed stimulus pushes expected commands/returns, monitors pop and compare.
module tb_sdram_arbiter;
    localparam int STARVE = 4;

    logic        clock = 1'b0, reset_n = 1'b0;
    logic [28:0] p0_address = '0, p1_address = '0;
    logic        p0_read = 1'b0, p1_read = 1'b0, p1_write = 1'b0;
    logic [63:0] p1_writedata = '0;
    logic [7:0]  p1_byteenable = '0;
    logic        p0_waitrequest, p0_readdatavalid, p1_waitrequest, p1_readdatavalid;
    logic [63:0] p0_readdata, p1_readdata, m_writedata, m_readdata;
    logic [28:0] m_address;
    logic [7:0]  m_burstcount, m_byteenable;
    logic        m_read, m_write, m_readdatavalid;
    logic        m_waitrequest = 1'b0;
    logic [31:0] debug_value;

    logic        model_rdv = 1'b0, stray_rdv = 1'b0;
    logic [63:0] model_data = '0;
    assign m_readdatavalid = model_rdv | stray_rdv;
    assign m_readdata      = model_data;

    sdram_arbiter #(.OUTSTANDING_LOG2(4), .STARVE_LIMIT(STARVE)) dut (
        .clock(clock), .reset_n(reset_n),
        .p0_address(p0_address), .p0_read(p0_read), .p0_waitrequest(p0_waitrequest),
        .p0_readdata(p0_readdata), .p0_readdatavalid(p0_readdatavalid),
        .p1_address(p1_address), .p1_read(p1_read), .p1_write(p1_write),
        .p1_writedata(p1_writedata), .p1_byteenable(p1_byteenable),
        .p1_waitrequest(p1_waitrequest), .p1_readdata(p1_readdata),
        .p1_readdatavalid(p1_readdatavalid),
        .m_address(m_address), .m_burstcount(m_burstcount), .m_read(m_read),
        .m_write(m_write), .m_writedata(m_writedata), .m_byteenable(m_byteenable),
        .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
        .m_readdatavalid(m_readdatavalid), .debug_value(debug_value)
    );

    always #5 clock = ~clock;

    typedef struct { int port; logic [28:0] addr; logic wr; logic [63:0] wdata; logic [7:0] be; } cmd_exp_t;
    typedef struct { int port; logic [63:0] data; } ret_exp_t;
    typedef struct { int due; logic [63:0] data; } pend_t;

    cmd_exp_t exp_cmd[$];
    ret_exp_t exp_ret[$];
    pend_t    pend[$];
    int       checks = 0, errors = 0;
    int       cyc = 0;
    int       lat = 5;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [63:0] mem_data(input logic [28:0] a);
        return {32'hCAFE0000, 3'b000, a};
    endfunction

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Controller model: fixed-latency in-order read returns.
    always @(negedge clock)
        if (reset_n && m_read && !m_waitrequest)
            pend.push_back('{cyc + lat, mem_data(m_address)});

    always @(posedge clock) begin
        #1;
        model_rdv = 1'b0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            model_rdv  = 1'b1;
            model_data = pend[0].data;
            void'(pend.pop_front());
        end
    end

    // Monitor: compares accepted commands and routed returns against the scoreboard.
    always @(negedge clock) begin : monitor
        cmd_exp_t e;
        ret_exp_t r;
        int       ap;
        if (reset_n) begin
            if ((m_read || m_write) && !m_waitrequest) begin
                chk(exp_cmd.size() != 0, "cmd_unexpected", {35'b0, m_address}, 0);
                if (exp_cmd.size() != 0) begin
                    e  = exp_cmd.pop_front();
                    ap = !p0_waitrequest ? 0 : (!p1_waitrequest ? 1 : -1);
                    chk(ap == e.port, "cmd_port", 64'(ap), 64'(e.port));
                    chk(m_address == e.addr && m_write == e.wr && m_read == !e.wr,
                        "cmd_addr_kind", {34'b0, m_write, m_address}, {34'b0, e.wr, e.addr});
                    chk(m_byteenable == e.be, "cmd_be", {56'b0, m_byteenable}, {56'b0, e.be});
                    if (e.wr) chk(m_writedata == e.wdata, "cmd_wdata", m_writedata, e.wdata);
                end
            end
            if (p0_readdatavalid || p1_readdatavalid) begin
                chk(exp_ret.size() != 0, "ret_unexpected", {62'b0, p1_readdatavalid, p0_readdatavalid}, 0);
                if (exp_ret.size() != 0) begin
                    r  = exp_ret.pop_front();
                    ap = p0_readdatavalid ? 0 : 1;
                    chk(!(p0_readdatavalid && p1_readdatavalid) && ap == r.port, "ret_port",
                        {62'b0, p1_readdatavalid, p0_readdatavalid}, 64'(r.port));
                    chk((ap == 0 ? p0_readdata : p1_readdata) == r.data, "ret_data",
                        (ap == 0 ? p0_readdata : p1_readdata), r.data);
                end
            end
            if (m_readdatavalid && !stray_rdv && !(p0_readdatavalid || p1_readdatavalid))
                chk(1'b0, "ret_lost", 0, 1);
        end
    end

    task automatic exp_rd(input int port, input logic [28:0] a, input logic [7:0] be);
        exp_cmd.push_back('{port, a, 1'b0, 64'd0, be});
        exp_ret.push_back('{port, mem_data(a)});
    endtask

    task automatic exp_wr(input logic [28:0] a, input logic [63:0] d, input logic [7:0] be);
        exp_cmd.push_back('{1, a, 1'b1, d, be});
    endtask

    task automatic p0_issue(input logic [28:0] a);
        int n = 0;
        p0_address = a;
        p0_read    = 1'b1;
        do begin @(negedge clock); n++; end while (p0_waitrequest && n < 300);
        chk(!p0_waitrequest, "p0_accept_timeout", 64'(n), 0);
        @(posedge clock); #1;
        p0_read = 1'b0;
    endtask

    task automatic p1_issue(input logic [28:0] a, input logic wr, input logic [63:0] d, input logic [7:0] be);
        int n = 0;
        p1_address    = a;
        p1_read       = !wr;
        p1_write      = wr;
        p1_writedata  = d;
        p1_byteenable = be;
        do begin @(negedge clock); n++; end while (p1_waitrequest && n < 300);
        chk(!p1_waitrequest, "p1_accept_timeout", 64'(n), 0);
        @(posedge clock); #1;
        p1_read  = 1'b0;
        p1_write = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_cmd.size() != 0 || exp_ret.size() != 0 || pend.size() != 0) && n < 500) begin
            @(negedge clock); n++;
        end
        chk(exp_cmd.size() == 0 && exp_ret.size() == 0, name,
            64'(exp_cmd.size() + exp_ret.size()), 0);
        @(posedge clock); #1;
    endtask

    initial begin
        repeat (2) @(negedge clock);
        chk(!m_read && !m_write, "reset_m_cmd", {62'b0, m_read, m_write}, 0);
        chk(p0_waitrequest && p1_waitrequest, "reset_waitrequest",
            {62'b0, p0_waitrequest, p1_waitrequest}, 3);
        chk(!p0_readdatavalid && !p1_readdatavalid, "reset_rdv",
            {62'b0, p0_readdatavalid, p1_readdatavalid}, 0);
        chk(debug_value == 32'd0, "reset_debug", {32'b0, debug_value}, 0);
        chk(m_burstcount == 8'h01, "burstcount", {56'b0, m_burstcount}, 1);
        @(posedge clock); #1 reset_n = 1'b1;
        @(posedge clock); #1;

        // Single port-0 read, controller latency 5
        exp_rd(0, 29'h100, 8'hFF);
        fork
            p0_issue(29'h100);
            begin
                @(negedge clock);
                chk(m_read && m_address == 29'h100, "t1_same_cycle_addr", {35'b0, m_address}, 64'h100);
            end
        join
        @(negedge clock);
        chk(debug_value[20:16] == 5'd1, "t1_outstanding", {59'b0, debug_value[20:16]}, 1);
        wait_drain("t1_drain");

        // Simultaneous reads: port 0 first, then port 1
        exp_rd(0, 29'h110, 8'hFF);
        exp_rd(1, 29'h120, 8'h0F);
        fork
            p0_issue(29'h110);
            p1_issue(29'h120, 1'b0, 64'd0, 8'h0F);
        join
        wait_drain("t2_drain");

        // Stalled port-1 write holds m_* against a later port-0 read
        m_waitrequest = 1'b1;
        exp_wr(29'h130, 64'h1122334455667788, 8'hF0);
        exp_rd(0, 29'h140, 8'hFF);
        fork
            p1_issue(29'h130, 1'b1, 64'h1122334455667788, 8'hF0);
            begin @(posedge clock); #1; p0_issue(29'h140); end
            begin
                @(negedge clock); @(negedge clock);
                chk(m_write && !m_read && p0_waitrequest && m_address == 29'h130, "t3_lock_hold",
                    {32'b0, m_write, m_read, p0_waitrequest, m_address}, {32'b0, 3'b101, 29'h130});
            end
            begin repeat (3) @(posedge clock); #1 m_waitrequest = 1'b0; end
        join
        wait_drain("t3_drain");

        // Full tag FIFO: write passes, read waits for a return
        lat = 40;
        for (int i = 0; i < 16; i++) begin
            exp_rd(0, 29'h200 + 29'(i), 8'hFF);
            p0_issue(29'h200 + 29'(i));
        end
        @(negedge clock);
        chk(debug_value[20:16] == 5'd16, "t4_full_count", {59'b0, debug_value[20:16]}, 16);
        @(posedge clock); #1;
        exp_wr(29'h400, 64'hA5A5_0000_5A5A_FFFF, 8'hFF);
        exp_rd(0, 29'h300, 8'hFF);
        fork
            p0_issue(29'h300);
            p1_issue(29'h400, 1'b1, 64'hA5A5_0000_5A5A_FFFF, 8'hFF);
            begin
                int n = 0;
                do begin @(negedge clock); n++; end while (!(m_write && !m_waitrequest) && n < 100);
                chk(debug_value[20:16] == 5'd16 && p0_waitrequest, "t4_write_while_full",
                    {58'b0, p0_waitrequest, debug_value[20:16]}, {58'b0, 1'b1, 5'd16});
            end
            begin
                int n = 0;
                do begin @(negedge clock); n++; end while (!m_readdatavalid && n < 100);
                chk(m_readdatavalid && p0_waitrequest && !m_read, "t4_read_stalled",
                    {61'b0, m_readdatavalid, p0_waitrequest, m_read}, 64'b110);
            end
        join
        wait_drain("t4_drain");
        lat = 5;

        // Stray return
        stray_rdv = 1'b1;
        @(negedge clock);
        chk(!p0_readdatavalid && !p1_readdatavalid, "t5_stray_dropped",
            {62'b0, p0_readdatavalid, p1_readdatavalid}, 0);
        @(posedge clock); #1 stray_rdv = 1'b0;
        @(negedge clock);
        chk(debug_value[31] && debug_value[20:16] == 5'd0, "t5_error_sticky",
            {32'b0, debug_value}, 64'h8000_0000);
        @(posedge clock); #1;

        // Continuous port-0 reads against a waiting port-1 read
`ifdef ARB_STARVATION_GUARD_EN
        for (int i = 0; i < STARVE; i++) exp_rd(0, 29'h500 + 29'(i), 8'hFF);
        exp_rd(1, 29'h600, 8'hFF);
        for (int i = STARVE; i < 10; i++) exp_rd(0, 29'h500 + 29'(i), 8'hFF);
`else
        for (int i = 0; i < 10; i++) exp_rd(0, 29'h500 + 29'(i), 8'hFF);
        exp_rd(1, 29'h600, 8'hFF);
`endif
        fork
            begin for (int i = 0; i < 10; i++) p0_issue(29'h500 + 29'(i)); end
            p1_issue(29'h600, 1'b0, 64'd0, 8'hFF);
        join
        wait_drain("t6_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
